// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the MIPS32 control units
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_R_WB     = 4'd3;
  localparam logic [3:0] S_EXEC_I   = 4'd4;
  localparam logic [3:0] S_I_WB     = 4'd5;
  localparam logic [3:0] S_MEM_ADDR = 4'd6;
  localparam logic [3:0] S_MEM_RD   = 4'd7;
  localparam logic [3:0] S_MEM_WB   = 4'd8;
  localparam logic [3:0] S_MEM_WR   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_ILLEGAL  = 4'd12;

  localparam logic       SRC_A_PC     = 1'b0;
  localparam logic       SRC_A_REG    = 1'b1;
  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Which operator rule the ALU decoder applies in the current cycle.
  typedef enum logic [2:0] {
    ALU_CLS_NONE,
    ALU_CLS_ADD,
    ALU_CLS_SUB,
    ALU_CLS_R,
    ALU_CLS_I
  } alu_cls_e;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - control unit to datapath signal bundle
interface mips_multicycle_ctrl_if #(
  parameter int OP    = 4,
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             alu_zero;
  logic             mem_ready;
  logic [OP-1:0]    operador;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic             ext_zero;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic [1:0]       pc_source;
  logic             pc_en;
  logic             retire;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output operador, alu_src_a, alu_src_b, ext_zero, iord, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, pc_source, pc_en, retire,
           illegal, instr_count
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  operador, alu_src_a, alu_src_b, ext_zero, iord, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, pc_source, pc_en, retire,
           illegal, instr_count
  );
endinterface

// File: rtl/mips_alu_decode.sv
// rtl/mips_alu_decode.sv - maps opcode/funct and operator class to an ALU op code
module mips_alu_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  alu_cls_e   cls_i,
  output logic [3:0] op_o,
  output logic       invalid_o
);
  always_comb begin
    op_o      = ALU_AND;
    invalid_o = 1'b0;
    case (cls_i)
      ALU_CLS_ADD: op_o = ALU_ADD;
      ALU_CLS_SUB: op_o = ALU_SUB;
      ALU_CLS_R: begin
        case (funct_i)
          FN_ADD:  op_o = ALU_ADD;
          FN_SUB:  op_o = ALU_SUB;
          FN_AND:  op_o = ALU_AND;
          FN_OR:   op_o = ALU_OR;
          FN_SLT:  op_o = ALU_SLT;
          FN_NOR:  op_o = ALU_NOR;
          default: invalid_o = 1'b1;
        endcase
      end
      ALU_CLS_I: begin
        case (opcode_i)
          OPC_ADDI: op_o = ALU_ADD;
          OPC_ANDI: op_o = ALU_AND;
          OPC_ORI:  op_o = ALU_OR;
          OPC_SLTI: op_o = ALU_SLT;
          default:  invalid_o = 1'b1;
        endcase
      end
      default: op_o = ALU_AND;
    endcase
  end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS32 sequencing control unit
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int OP      = 4,
  parameter bit ZERO_EQ = 1'b0,
  parameter int CNT_W   = 32
) (
  input logic                    clk,
  input logic                    rst,
  mips_multicycle_ctrl_if.master bus
);
  logic [3:0]       state_q, state_d;
  logic             illegal_q;
  logic [CNT_W-1:0] count_q;
  alu_cls_e         alu_cls;
  logic [3:0]       alu_op;
  logic             alu_invalid;
  logic             src_a, ext_zero, iord, mem_read, mem_write, ir_write;
  logic             reg_dst, mem_to_reg, reg_write, pc_en, retire;
  logic [1:0]       src_b, pc_source;

  mips_alu_decode u_alu_decode (
    .opcode_i  (bus.opcode),
    .funct_i   (bus.funct),
    .cls_i     (alu_cls),
    .op_o      (alu_op),
    .invalid_o (alu_invalid)
  );

  // Kept apart from the main decode so alu_invalid never feeds back into its own source block.
  always_comb begin
    alu_cls = ALU_CLS_NONE;
    if (!rst) begin
      case (state_q)
        S_FETCH, S_DECODE, S_MEM_ADDR: alu_cls = ALU_CLS_ADD;
        S_EXEC_R:                      alu_cls = ALU_CLS_R;
        S_EXEC_I:                      alu_cls = ALU_CLS_I;
        S_BRANCH:                      alu_cls = ALU_CLS_SUB;
        default:                       alu_cls = ALU_CLS_NONE;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    src_a      = SRC_A_PC;
    src_b      = SRC_B_REG;
    ext_zero   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    pc_source  = PC_SRC_ALU;
    pc_en      = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        src_b    = SRC_B_FOUR;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        src_b = SRC_B_IMM_SH;
        case (bus.opcode)
          OPC_RTYPE:                             state_d = S_EXEC_R;
          OPC_LW, OPC_SW:                        state_d = S_MEM_ADDR;
          OPC_BEQ:                               state_d = S_BRANCH;
          OPC_J:                                 state_d = S_JUMP;
          OPC_ADDI, OPC_ANDI, OPC_ORI, OPC_SLTI: state_d = S_EXEC_I;
          default:                               state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        src_a   = SRC_A_REG;
        state_d = alu_invalid ? S_ILLEGAL : S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC_I: begin
        src_a    = SRC_A_REG;
        src_b    = SRC_B_IMM;
        ext_zero = (bus.opcode == OPC_ANDI) || (bus.opcode == OPC_ORI);
        state_d  = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        src_a   = SRC_A_REG;
        src_b   = SRC_B_IMM;
        state_d = (bus.opcode == OPC_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (bus.mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        src_a     = SRC_A_REG;
        pc_source = PC_SRC_ALUOUT;
        pc_en     = (bus.alu_zero == ZERO_EQ);
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_source = PC_SRC_JUMP;
        pc_en     = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_FETCH;
    endcase
    // Reset wins over everything so an abandoned instruction leaves no side effects.
    if (rst) begin
      state_d    = S_FETCH;
      src_a      = 1'b0;
      src_b      = 2'b00;
      ext_zero   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      pc_source  = 2'b00;
      pc_en      = 1'b0;
      retire     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ILLEGAL) illegal_q <= 1'b1;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.operador    = OP'(alu_op);
  assign bus.alu_src_a   = src_a;
  assign bus.alu_src_b   = src_b;
  assign bus.ext_zero    = ext_zero;
  assign bus.iord        = iord;
  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.ir_write    = ir_write;
  assign bus.reg_dst     = reg_dst;
  assign bus.mem_to_reg  = mem_to_reg;
  assign bus.reg_write   = reg_write;
  assign bus.pc_source   = pc_source;
  assign bus.pc_en       = pc_en;
  assign bus.retire      = retire;
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = count_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
  localparam int K_FW = 0, K_F = 1, K_DEC = 2, K_EXR = 3, K_RWB = 4, K_EXI = 5, K_IWB = 6;
  localparam int K_ADDR = 7, K_RDW = 8, K_RD = 9, K_MWB = 10, K_WRW = 11, K_WR = 12;
  localparam int K_BR = 13, K_J = 14, K_ILL = 15, K_RST = 16;

  // -1 in any field means the output is not defined for that step.
  typedef struct {
    int op, sa, sb, ez, iord, mr, mw, irw, rdst, m2r, rw, pcs, pce, ret, ill, cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  exp_t e;
  int   m_count = 0;
  int   m_illegal = 0;

  mips_multicycle_ctrl_if #(.OP(4), .CNT_W(4)) bus ();

  mips_multicycle_ctrl #(.OP(4), .ZERO_EQ(1'b0), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int want, input int got);
    if (want >= 0) begin
      checks++;
      if (got != want) begin
        errors++;
        $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
      end
    end
  endtask

  function automatic int alu_of_funct(input logic [5:0] fn);
    case (fn)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      6'b100111: return 12;
      default:   return -1;
    endcase
  endfunction

  function automatic exp_t step_exp(input int k, input logic [5:0] opc, input logic [5:0] fn, input bit zero);
    exp_t x;
    x = '{op: -1, sa: -1, sb: -1, ez: -1, iord: -1, mr: 0, mw: 0, irw: 0, rdst: -1,
          m2r: -1, rw: 0, pcs: -1, pce: 0, ret: 0, ill: -1, cnt: -1};
    case (k)
      K_FW, K_F: begin
        x.mr = 1; x.iord = 0; x.sa = 0; x.sb = 1; x.op = 2; x.pcs = 0;
        if (k == K_F) begin x.irw = 1; x.pce = 1; end
      end
      K_DEC: begin x.sa = 0; x.sb = 3; x.op = 2; end
      K_EXR: begin x.sa = 1; x.sb = 0; x.op = alu_of_funct(fn); end
      K_RWB: begin x.rw = 1; x.rdst = 1; x.m2r = 0; x.ret = 1; end
      K_EXI: begin
        x.sa = 1; x.sb = 2;
        case (opc)
          6'b001000: begin x.op = 2; x.ez = 0; end
          6'b001100: begin x.op = 0; x.ez = 1; end
          6'b001101: begin x.op = 1; x.ez = 1; end
          default:   begin x.op = 7; x.ez = 0; end
        endcase
      end
      K_IWB: begin x.rw = 1; x.rdst = 0; x.m2r = 0; x.ret = 1; end
      K_ADDR: begin x.sa = 1; x.sb = 2; x.op = 2; x.ez = 0; end
      K_RDW, K_RD: begin x.iord = 1; x.mr = 1; end
      K_MWB: begin x.rw = 1; x.rdst = 0; x.m2r = 1; x.ret = 1; end
      K_WRW, K_WR: begin x.iord = 1; x.mw = 1; if (k == K_WR) x.ret = 1; end
      K_BR: begin x.sa = 1; x.sb = 0; x.op = 6; x.pcs = 1; x.pce = zero ? 0 : 1; x.ret = 1; end
      K_J: begin x.pcs = 2; x.pce = 1; x.ret = 1; end
      K_RST: begin
        x.op = 0; x.sa = 0; x.sb = 0; x.ez = 0; x.iord = 0; x.rdst = 0; x.m2r = 0; x.pcs = 0;
      end
      default: ;
    endcase
    return x;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("operador", e.op, int'(bus.operador));
      chk("alu_src_a", e.sa, int'(bus.alu_src_a));
      chk("alu_src_b", e.sb, int'(bus.alu_src_b));
      chk("ext_zero", e.ez, int'(bus.ext_zero));
      chk("iord", e.iord, int'(bus.iord));
      chk("mem_read", e.mr, int'(bus.mem_read));
      chk("mem_write", e.mw, int'(bus.mem_write));
      chk("ir_write", e.irw, int'(bus.ir_write));
      chk("reg_dst", e.rdst, int'(bus.reg_dst));
      chk("mem_to_reg", e.m2r, int'(bus.mem_to_reg));
      chk("reg_write", e.rw, int'(bus.reg_write));
      chk("pc_source", e.pcs, int'(bus.pc_source));
      chk("pc_en", e.pce, int'(bus.pc_en));
      chk("retire", e.ret, int'(bus.retire));
      chk("illegal", e.ill, int'(bus.illegal));
      chk("instr_count", e.cnt, int'(bus.instr_count));
    end
  end

  // Builds the expected step trace of one instruction from the latency rules, then plays it.
  task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input int fw, input int waits,
                           input bit zero, input int rst_at, input int pin_cnt, output int lat);
    int   q[$];
    exp_t x;
    for (int i = 0; i < fw; i++) q.push_back(K_FW);
    q.push_back(K_F);
    q.push_back(K_DEC);
    case (opc)
      6'b000000: begin
        q.push_back(K_EXR);
        if (alu_of_funct(fn) >= 0) q.push_back(K_RWB);
        else repeat (3) q.push_back(K_ILL);
      end
      6'b100011: begin
        q.push_back(K_ADDR);
        for (int i = 0; i < waits; i++) q.push_back(K_RDW);
        q.push_back(K_RD);
        q.push_back(K_MWB);
      end
      6'b101011: begin
        q.push_back(K_ADDR);
        for (int i = 0; i < waits; i++) q.push_back(K_WRW);
        q.push_back(K_WR);
      end
      6'b000100: q.push_back(K_BR);
      6'b000010: q.push_back(K_J);
      6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
        q.push_back(K_EXI);
        q.push_back(K_IWB);
      end
      default: repeat (3) q.push_back(K_ILL);
    endcase
    if (rst_at >= 0) begin
      while (q.size() > rst_at) void'(q.pop_back());
      q.push_back(K_RST);
    end else if (q[$] == K_ILL) begin
      q.push_back(K_RST);
    end
    lat = -1;
    foreach (q[i]) begin
      @(posedge clk);
      #1;
      rst           = (q[i] == K_RST);
      bus.mem_ready = !(q[i] inside {K_FW, K_RDW, K_WRW});
      bus.alu_zero  = zero;
      bus.opcode    = opc;
      bus.funct     = fn;
      x     = step_exp(q[i], opc, fn, zero);
      x.cnt = m_count;
      x.ill = m_illegal;
      e      = x;
      chk_en = 1'b1;
      @(negedge clk);
      if (i == 0 && pin_cnt >= 0) chk("count_pin", pin_cnt, int'(bus.instr_count));
      if (bus.retire && lat < 0) lat = i + 1;
      if (q[i] == K_RST) begin
        m_count   = 0;
        m_illegal = 0;
      end else begin
        if (x.ret == 1) m_count = (m_count + 1) % 16;
        if (q[i] == K_ILL) m_illegal = 1;
      end
    end
  endtask

  initial begin
    int lat;
    logic [5:0] rfn [5];
    rfn = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    bus.opcode = '0; bus.funct = '0; bus.alu_zero = 1'b0; bus.mem_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    e = step_exp(K_RST, 6'd0, 6'd0, 1'b0);
    e.cnt = 0;
    e.ill = 0;
    chk_en = 1'b1;
    @(negedge clk);

    run_instr(6'b000000, 6'b100000, 0, 0, 1'b0, -1, -1, lat);
    chk("lat_add", 4, lat);
    run_instr(6'b100011, 6'd0, 0, 3, 1'b0, -1, 1, lat);
    chk("lat_lw_wait3", 8, lat);
    run_instr(6'b000100, 6'd0, 0, 0, 1'b0, -1, -1, lat);
    chk("lat_beq_taken", 3, lat);
    run_instr(6'b000100, 6'd0, 0, 0, 1'b1, -1, -1, lat);
    chk("lat_beq_not_taken", 3, lat);
    run_instr(6'b001000, 6'd0, 2, 0, 1'b0, -1, -1, lat);
    chk("lat_addi_fetch_wait2", 6, lat);
    run_instr(6'b001100, 6'd0, 0, 0, 1'b0, -1, -1, lat);
    run_instr(6'b001101, 6'd0, 0, 0, 1'b0, -1, -1, lat);
    run_instr(6'b001010, 6'd0, 0, 0, 1'b0, -1, -1, lat);
    chk("lat_slti", 4, lat);
    foreach (rfn[i]) run_instr(6'b000000, rfn[i], 0, 0, 1'b0, -1, -1, lat);
    run_instr(6'b101011, 6'd0, 0, 1, 1'b0, -1, -1, lat);
    chk("lat_sw_wait1", 5, lat);
    run_instr(6'b101011, 6'd0, 0, 2, 1'b0, 4, -1, lat);
    chk("sw_reset_no_retire", -1, lat);
    run_instr(6'b000000, 6'b000111, 0, 0, 1'b0, -1, 0, lat);
    chk("illegal_funct_no_retire", -1, lat);
    run_instr(6'b111111, 6'd0, 0, 0, 1'b0, -1, 0, lat);
    for (int i = 0; i < 16; i++) begin
      run_instr(6'b000010, 6'd0, 0, 0, 1'b0, -1, i, lat);
      chk("lat_j", 3, lat);
    end
    run_instr(6'b000010, 6'd0, 0, 0, 1'b0, -1, 0, lat);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Sequencing control unit for the multicycle MIPS32 datapath.
- Walks each instruction through FETCH, DECODE, EXECUTE, MEM and WB states.
- Drives the ALU operator code together with every datapath mux select and write enable.
- Consumes the ALU zero flag to resolve BEQ; sits between the instruction register and the shared ALU/register-file/memory datapath.

Parameters:
- OP, 4, width of ALU operator code.
- ZERO_EQ, 0, value of alu_zero meaning "operands equal" (0: the ALU flag asserts on a nonzero difference).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], stable from DECODE onward
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU zero flag, sampled in BRANCH
- mem_ready  in  1  memory handshake; access completes in the cycle it is 1
- operador  out  OP  ALU operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- alu_src_a  out  1  0: PC, 1: register A
- alu_src_b  out  2  00: B, 01: const 4, 10: ext imm, 11: ext imm<<2
- ext_zero  out  1  1: zero-extend immediate, 0: sign-extend
- iord  out  1  memory address: 0: PC, 1: ALUOut
- mem_read / mem_write  out  1 each  memory strobes
- ir_write  out  1  load IR
- reg_dst  out  1  0: rt, 1: rd
- mem_to_reg  out  1  0: ALUOut, 1: MDR
- reg_write  out  1  register-file write enable
- pc_source  out  2  00: ALU result, 01: ALUOut, 10: jump target
- pc_en  out  1  PC load enable (branch resolved internally)
- retire  out  1  one-cycle pulse on instruction completion
- illegal  out  1  sticky illegal-instruction flag
- instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Reset:
  - While rst=1: state<=FETCH, illegal<=0, instr_count<=0; every enable/strobe output is 0 and operador=0000.
  - The first FETCH cycle occurs on the cycle after rst falls.
  - rst mid-instruction abandons it: no writes, no retire.
- Outputs are Moore-decoded from the state. EXECUTE's operador also depends on funct/opcode.
- States and transitions:
  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, operador=ADD, pc_source=00.
    - While mem_ready=0: stay; ir_write=0, pc_en=0.
    - When mem_ready=1: ir_write=1, pc_en=1, next DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, operador=ADD (branch target into ALUOut). Next state by opcode:
    - 000000 → EXEC_R
    - 100011/101011 → MEM_ADDR
    - 000100 → BRANCH
    - 000010 → JUMP
    - 001000/001100/001101/001010 → EXEC_I
    - other → ILLEGAL
  - EXEC_R: alu_src_a=1, alu_src_b=00. operador from funct:
    - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR
    - Next R_WB; unknown funct → ILLEGAL.
  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, retire → FETCH.
  - EXEC_I: alu_src_a=1, alu_src_b=10.
    - addi: ADD, ext_zero=0
    - andi: AND, ext_zero=1
    - ori: OR, ext_zero=1
    - slti: SLT, ext_zero=0
    - Next I_WB.
  - I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, retire → FETCH.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, operador=ADD, ext_zero=0 → MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD: iord=1, mem_read=1. Hold until mem_ready=1, then → MEM_WB.
  - MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, retire → FETCH.
  - MEM_WR: iord=1, mem_write=1. Hold until mem_ready; on mem_ready=1 retire → FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, operador=SUB, pc_source=01, pc_en=(alu_zero==ZERO_EQ), retire → FETCH.
  - JUMP: pc_source=10, pc_en=1, retire → FETCH.
  - ILLEGAL: illegal<=1, all enables 0. Terminal until rst.
- Latency with mem_ready tied to 1:
  - R-type, immediate, sw: 4 cycles
  - lw: 5 cycles
  - beq, j: 3 cycles
  - Each cycle mem_ready=0 in a memory state adds one cycle.
- instr_count increments on retire and wraps modulo 2^CNT_W.
- mem_read and mem_write are never both 1. reg_write and pc_en may coincide only if the datapath allows; they never do in this FSM.

Decomposition:
- Shared package mips_pkg:
  - ALU op constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR)
  - opcode/funct constants
  - state encoding
  - mux-select constants
- One sub-module, mips_alu_decode (combinational): maps opcode/funct/state-class to operador and an invalid flag. Reused by a later pipelined control unit.

Test Plan:
- add ($t0=$t1+$t2: opcode 000000, funct 100000), mem_ready=1 → FETCH, DECODE, EXEC_R, R_WB. operador=0010 in EXEC_R; reg_write=1, reg_dst=1 in cycle 4; retire once; instr_count=1.
- lw with mem_ready low for 3 cycles in MEM_RD → stays in MEM_RD 4 cycles with mem_read=1, iord=1. Then MEM_WB with mem_to_reg=1; total 8 cycles.
- beq with alu_zero=0 (ZERO_EQ=0) → pc_en=1, pc_source=01 in BRANCH. Repeat with alu_zero=1 → pc_en=0; both retire after 3 cycles.
- funct 000111 in R-type → ILLEGAL after EXEC_R entry. illegal=1 sticky, no reg_write; rst=1 for 1 cycle clears it and the FSM restarts in FETCH.
- rst asserted during MEM_WR → next cycle mem_write=0, state FETCH, instr_count=0, no retire.
- instr_count preset near wrap (CNT_W=4, 16 retires of j) → counts 1..15 then 0.
